// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: detects load-use and carry-flag hazards
// between ID and EX, squashes wrong-path fetches after a taken branch,
// freezes the back end while data memory is busy, and counts stall cycles.
// Control outputs are combinational from the registered state and the
// current inputs, so they take effect in the cycle a hazard is seen.
module hazard_stall_ctrl #(
    parameter int RS_LSB            = 8,
    parameter int RT_LSB            = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLAG_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int PERF_W            = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [18:0]       id_instr,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_uses_carry,
    input  logic [2:0]        ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_is_load,
    input  logic              ex_write_c,
    input  logic              ex_branch_taken,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              pipe_hold,
    output logic [1:0]        ctrl_state,
    output logic [PERF_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // The cycle that enters STALL/FLUSH is itself the first extra cycle's
    // predecessor, so the down-counter is loaded with (cycles - 2).
    localparam logic [1:0] LOAD_RELOAD  = 2'((LOAD_STALL_CYCLES > 1) ? LOAD_STALL_CYCLES - 2 : 0);
    localparam logic [1:0] FLAG_RELOAD  = 2'((FLAG_STALL_CYCLES > 1) ? FLAG_STALL_CYCLES - 2 : 0);
    localparam logic [1:0] FLUSH_RELOAD = 2'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [PERF_W-1:0] stall_count_q;

    logic [1:0] src_match;
    logic [1:0] src_used;
    logic       load_haz;
    logic       flag_haz;

    logic pc_write_c;
    logic if_id_write_c;
    logic if_id_flush_c;
    logic id_ex_bubble_c;
    logic pipe_hold_c;

    // Only the rs/rt fields of the instruction matter; the rest is ignored.
    logic unused_instr_bits;
    assign unused_instr_bits = ^id_instr;

    // Per-source register comparison against the EX destination (r0 included).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            localparam int FIELD_LSB = (gi == 0) ? RS_LSB : RT_LSB;
            assign src_match[gi] = (id_instr[FIELD_LSB +: 3] == ex_rd);
        end
    endgenerate

    assign src_used = {id_uses_rt, id_uses_rs};
    assign load_haz = ex_is_load & ex_reg_write & (|(src_match & src_used));
    assign flag_haz = id_uses_carry & ex_write_c;

    // Control decode and next-state selection; reset and memory freeze win.
    always_comb begin
        pc_write_c     = 1'b0;
        if_id_write_c  = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_bubble_c = 1'b0;
        pipe_hold_c    = 1'b0;
        state_d        = state_q;
        cnt_d          = cnt_q;

        if (reset) begin
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
            state_d        = ST_RUN;
            cnt_d          = 2'd0;
        end else if (mem_busy) begin
            pipe_hold_c = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        // Branch beats any hazard: the ID instruction is wrong-path.
                        pc_write_c     = 1'b1;
                        if_id_write_c  = 1'b1;
                        if_id_flush_c  = 1'b1;
                        id_ex_bubble_c = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = ST_FLUSH;
                            cnt_d   = FLUSH_RELOAD;
                        end
                    end else if (load_haz) begin
                        id_ex_bubble_c = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = ST_STALL;
                            cnt_d   = LOAD_RELOAD;
                        end
                    end else if (flag_haz) begin
                        id_ex_bubble_c = 1'b1;
                        if (FLAG_STALL_CYCLES > 1) begin
                            state_d = ST_STALL;
                            cnt_d   = FLAG_RELOAD;
                        end
                    end else begin
                        pc_write_c    = 1'b1;
                        if_id_write_c = 1'b1;
                    end
                end
                ST_STALL: begin
                    id_ex_bubble_c = 1'b1;
                    if (cnt_q == 2'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = 2'(cnt_q - 2'd1);
                    end
                end
                ST_FLUSH: begin
                    // EX holds a bubble here, so a taken-branch input is stale.
                    pc_write_c     = 1'b1;
                    if_id_write_c  = 1'b1;
                    if_id_flush_c  = 1'b1;
                    id_ex_bubble_c = 1'b1;
                    if (cnt_q == 2'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = 2'(cnt_q - 2'd1);
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    // State, down-counter and saturating stall counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            cnt_q         <= 2'd0;
            stall_count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!pc_write_c && (stall_count_q != {PERF_W{1'b1}})) begin
                stall_count_q <= stall_count_q + 1'b1;
            end
        end
    end

    assign pc_write     = pc_write_c;
    assign if_id_write  = if_id_write_c;
    assign if_id_flush  = if_id_flush_c;
    assign id_ex_bubble = id_ex_bubble_c;
    assign pipe_hold    = pipe_hold_c;
    assign ctrl_state   = state_q;
    assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized bench for hazard_stall_ctrl: three instances with different
// stall/flush lengths and counter widths share one stimulus stream, each
// checked every cycle against a remaining-cycles reference model.
module tb_hazard_stall_ctrl;

    localparam int NCYC = 2000;
    localparam int NI   = 3;

    // Per-instance configuration: load, flag, flush cycles and counter width.
    int cfg_load [NI] = '{1, 3, 2};
    int cfg_flag [NI] = '{1, 2, 3};
    int cfg_flush[NI] = '{1, 2, 3};
    int cfg_pw   [NI] = '{16, 4, 5};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [18:0] id_instr = '0;
    logic        id_uses_rs = 1'b0;
    logic        id_uses_rt = 1'b0;
    logic        id_uses_carry = 1'b0;
    logic [2:0]  ex_rd = '0;
    logic        ex_reg_write = 1'b0;
    logic        ex_is_load = 1'b0;
    logic        ex_write_c = 1'b0;
    logic        ex_branch_taken = 1'b0;
    logic        mem_busy = 1'b0;

    logic [4:0]  ctl_o [NI];
    logic [1:0]  st_o  [NI];
    logic [15:0] sc_a;
    logic [3:0]  sc_b;
    logic [4:0]  sc_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl u_a (
        .clk(clk), .reset(reset), .id_instr(id_instr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_uses_carry(id_uses_carry),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .ex_write_c(ex_write_c), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(ctl_o[0][4]), .if_id_write(ctl_o[0][3]), .if_id_flush(ctl_o[0][2]),
        .id_ex_bubble(ctl_o[0][1]), .pipe_hold(ctl_o[0][0]),
        .ctrl_state(st_o[0]), .stall_count(sc_a)
    );

    hazard_stall_ctrl #(
        .LOAD_STALL_CYCLES(3), .FLAG_STALL_CYCLES(2), .FLUSH_CYCLES(2), .PERF_W(4)
    ) u_b (
        .clk(clk), .reset(reset), .id_instr(id_instr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_uses_carry(id_uses_carry),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .ex_write_c(ex_write_c), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(ctl_o[1][4]), .if_id_write(ctl_o[1][3]), .if_id_flush(ctl_o[1][2]),
        .id_ex_bubble(ctl_o[1][1]), .pipe_hold(ctl_o[1][0]),
        .ctrl_state(st_o[1]), .stall_count(sc_b)
    );

    hazard_stall_ctrl #(
        .LOAD_STALL_CYCLES(2), .FLAG_STALL_CYCLES(3), .FLUSH_CYCLES(3), .PERF_W(5)
    ) u_c (
        .clk(clk), .reset(reset), .id_instr(id_instr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_uses_carry(id_uses_carry),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .ex_write_c(ex_write_c), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_write(ctl_o[2][4]), .if_id_write(ctl_o[2][3]), .if_id_flush(ctl_o[2][2]),
        .id_ex_bubble(ctl_o[2][1]), .pipe_hold(ctl_o[2][0]),
        .ctrl_state(st_o[2]), .stall_count(sc_c)
    );

    // Reference state: cycles still owed to a stall or flush, and the counter.
    int rem_stall[NI];
    int rem_flush[NI];
    int perf     [NI];
    int nxt_stall[NI];
    int nxt_flush[NI];
    int nxt_perf [NI];

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One cycle of the reference: expected controls {pc,ifid,flush,bubble,hold},
    // expected state and the owed-cycle/counter values after the clock edge.
    task automatic model_step(
        input  int lc, input int fc, input int flc, input int pw,
        input  int rs_in, input int rf_in, input int cnt_in,
        output int ctl, output int st,
        output int rs_out, output int rf_out, output int cnt_out
    );
        int rs_f, rt_f;
        bit lh, fh;
        rs_f = (int'(id_instr) >> 8) & 7;
        rt_f = (int'(id_instr) >> 5) & 7;
        lh = ex_is_load && ex_reg_write &&
             ((id_uses_rs && rs_f == int'(ex_rd)) || (id_uses_rt && rt_f == int'(ex_rd)));
        fh = id_uses_carry && ex_write_c;
        st = (rs_in > 0) ? 1 : ((rf_in > 0) ? 2 : 0);
        rs_out  = rs_in;
        rf_out  = rf_in;
        cnt_out = cnt_in;
        if (reset) begin
            ctl = 5'b00110;
            rs_out = 0; rf_out = 0; cnt_out = 0;
        end else begin
            if (mem_busy)             ctl = 5'b00001;
            else if (rs_in > 0)       begin ctl = 5'b00010; rs_out = rs_in - 1; end
            else if (rf_in > 0)       begin ctl = 5'b11110; rf_out = rf_in - 1; end
            else if (ex_branch_taken) begin ctl = 5'b11110; rf_out = flc - 1; end
            else if (lh)              begin ctl = 5'b00010; rs_out = lc - 1; end
            else if (fh)              begin ctl = 5'b00010; rs_out = fc - 1; end
            else                      ctl = 5'b11000;
            if (((ctl >> 4) & 1) == 0 && cnt_in < (1 << pw) - 1) cnt_out = cnt_in + 1;
        end
    endtask

    function automatic int sc_of(input int k);
        case (k)
            0:       return int'(sc_a);
            1:       return int'(sc_b);
            default: return int'(sc_c);
        endcase
    endfunction

    initial begin
        for (int k = 0; k < NI; k++) begin
            rem_stall[k] = 0; rem_flush[k] = 0; perf[k] = 0;
        end
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            logic [18:0] instr;
            @(negedge clk);
            reset = (cyc < 2) || ($urandom_range(0, 79) == 0);
            mem_busy = (cyc >= 40 && cyc < 56) ? 1'b1 : ($urandom_range(0, 5) == 0);
            ex_rd = 3'($urandom_range(0, 7));
            instr = 19'($urandom);
            if ($urandom_range(0, 1) == 1) instr[10:8] = ex_rd;
            if ($urandom_range(0, 1) == 1) instr[7:5]  = ex_rd;
            id_instr        = instr;
            id_uses_rs      = 1'($urandom_range(0, 1));
            id_uses_rt      = 1'($urandom_range(0, 1));
            id_uses_carry   = ($urandom_range(0, 2) == 0);
            ex_reg_write    = ($urandom_range(0, 3) != 0);
            ex_is_load      = 1'($urandom_range(0, 1));
            ex_write_c      = ($urandom_range(0, 3) == 0);
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            #1;
            for (int k = 0; k < NI; k++) begin
                int ctl, st;
                model_step(cfg_load[k], cfg_flag[k], cfg_flush[k], cfg_pw[k],
                           rem_stall[k], rem_flush[k], perf[k],
                           ctl, st, nxt_stall[k], nxt_flush[k], nxt_perf[k]);
                check_val($sformatf("ctl%0d", k), int'(ctl_o[k]), ctl);
                check_val($sformatf("state%0d", k), int'(st_o[k]), st);
                check_val($sformatf("count%0d", k), sc_of(k), perf[k]);
            end
            $display("cyc=%0d rst=%0b busy=%0b br=%0b ld=%0b ctl=%b/%b/%b st=%0d/%0d/%0d cnt=%0d/%0d/%0d",
                     cyc, reset, mem_busy, ex_branch_taken, ex_is_load,
                     ctl_o[0], ctl_o[1], ctl_o[2], st_o[0], st_o[1], st_o[2],
                     sc_a, sc_b, sc_c);
            @(posedge clk);
            for (int k = 0; k < NI; k++) begin
                rem_stall[k] = nxt_stall[k];
                rem_flush[k] = nxt_flush[k];
                perf[k]      = nxt_perf[k];
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage 8-bit core.
- Issues stall, bubble, flush and freeze controls to the PC, IF/ID and ID/EX pipeline registers.
- Detects load-use hazards and carry-flag hazards between the ID and EX stages, squashes wrong-path instructions when EX resolves a taken branch, and freezes the whole pipe while memory is busy.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- RS_LSB, 8: LSB of 3-bit source-register field rs in the 19-bit instruction.
- RT_LSB, 5: LSB of 3-bit source-register field rt.
- LOAD_STALL_CYCLES, 1: bubbles inserted per load-use hazard (1..3).
- FLAG_STALL_CYCLES, 1: bubbles inserted per carry-flag hazard (1..3).
- FLUSH_CYCLES, 1: squash cycles per taken branch (1..3).
- PERF_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_instr  in  19  instruction currently in IF/ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_uses_carry  in  1  ID instruction's ALU consumes C.
- ex_rd  in  3  destination register of the EX instruction.
- ex_reg_write  in  1  EX instruction writes the register file.
- ex_is_load  in  1  EX instruction is a memory load.
- ex_write_c  in  1  EX instruction updates C.
- ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- mem_busy  in  1  data memory not ready.
- pc_write  out  1  PC may update.
- if_id_write  out  1  IF/ID may load.
- if_id_flush  out  1  IF/ID loads a NOP.
- id_ex_bubble  out  1  ID/EX loads zeroed controls (NOP).
- pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- ctrl_state  out  2  current state (0 RUN, 1 STALL, 2 FLUSH).
- stall_count  out  PERF_W  saturating count of cycles with pc_write=0.

Behaviour:
- Outputs are Mealy: combinational from the registered state/counter and the current inputs, so they act in the detecting cycle.
- Reset (sampled on clk edge):
  - Next state RUN; down-counter = 0; stall_count = 0.
  - While reset is high, outputs are forced: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, pipe_hold=0.
  - Reset mid-STALL or mid-FLUSH aborts to RUN.
- Hazard terms:
  - load_haz = ex_is_load & ex_reg_write & ((id_uses_rs & rs==ex_rd) | (id_uses_rt & rt==ex_rd)). Register 0 is not special.
  - flag_haz = id_uses_carry & ex_write_c.
- Freeze: mem_busy=1 in any state gives pipe_hold=1, pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=0. State and down-counter hold; hazards and branches are ignored that cycle.
- RUN, mem_busy=0, in priority order:
  1. ex_branch_taken:
     - Outputs: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1.
     - If FLUSH_CYCLES>1: go to FLUSH with cnt = FLUSH_CYCLES-2.
     - Branch beats a simultaneous hazard, because the ID instruction is squashed.
  2. load_haz:
     - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1.
     - If LOAD_STALL_CYCLES>1: go to STALL with cnt = LOAD_STALL_CYCLES-2.
  3. flag_haz: same as load_haz, using FLAG_STALL_CYCLES.
  4. Otherwise: pc_write=1, if_id_write=1, all other controls 0.
- STALL:
  - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1.
  - cnt==0 → RUN; else cnt-1.
  - No re-detection until RUN. The ID instruction is re-evaluated on return.
- FLUSH:
  - Outputs: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1.
  - cnt==0 → RUN; else cnt-1.
  - ex_branch_taken is ignored, since EX holds a bubble.
- stall_count:
  - Increments each non-reset cycle with pc_write=0, mem_busy freeze included.
  - Saturates at all-ones; no wrap.
- ctrl_state reflects the registered state.

Test Plan:
- Reset held 2 cycles, then released with no hazards → during reset pc_write=0, if_id_flush=1, id_ex_bubble=1, stall_count=0; after release pc_write=1, if_id_write=1, others 0, ctrl_state=0.
- Load-use: ex_is_load=1, ex_reg_write=1, ex_rd=3, id rs=3, id_uses_rs=1 → exactly one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1, stall_count=1. With LOAD_STALL_CYCLES=3 the stall lasts 3 cycles and ctrl_state=1 for 2 of them.
- Non-matches: ex_rd=3 with rs=3 but id_uses_rs=0, or rt=3 but ex_is_load=0 → no stall. id_uses_carry=1 & ex_write_c=1 → one-cycle bubble.
- Taken branch coincident with load_haz → flush wins: if_id_flush=1, id_ex_bubble=1, pc_write=1. With FLUSH_CYCLES=2 there is one extra FLUSH cycle (ctrl_state=2), then RUN.
- mem_busy asserted for 4 cycles mid-STALL (LOAD_STALL_CYCLES=3) → pipe_hold=1, cnt frozen, remaining stall cycles complete after release, stall_count increments on every cycle.
- Preload 2^PERF_W-2 stall cycles (PERF_W=4, i.e. 14 cycles of mem_busy), then 5 more stall cycles → stall_count stays at 15. Assert reset mid-FLUSH → next cycle ctrl_state=0.
